// File: rtl/fetch_stage_if.sv
// Fetch stage bus bundle: instruction-memory request/response, the
// decoder-facing valid/ready handshake and the execute redirect.
// master = fetch stage, slave = its environment (memory/decoder/execute).
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        decode_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req, imem_addr, instr, instr_pc, instr_valid,
        input  imem_rsp_valid, imem_rsp_data, decode_ready,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_pc, instr_valid,
        output imem_rsp_valid, imem_rsp_data, decode_ready,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one word read at a time and
// hands each instruction to the decoder over valid/ready. Redirects flush
// the held instruction and discard any in-flight response.
// Optional macro FETCH_PERF_CNT_EN adds the perf_fetched/perf_stall counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]   perf_fetched,
    output logic [31:0]   perf_stall
`endif
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic        outstanding;

    // A request is in flight exactly while waiting for or draining a response.
    assign outstanding = (state_q == S_WAIT) || (state_q == S_DRAIN);

    // The HOLD->WAIT request must leave in the same cycle as the handshake,
    // so the request is decoded from state and live inputs, not registered.
    assign bus.imem_req  = rst_n && !bus.redirect_valid &&
                           ((state_q == S_REQ) ||
                            ((state_q == S_HOLD) && bus.decode_ready));
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = instr_valid_q;

    // Next-state logic; redirect overrides every state transition.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        if (bus.redirect_valid) begin
            pc_d          = bus.redirect_pc;
            instr_valid_d = 1'b0;
            state_d       = (outstanding && !bus.imem_rsp_valid) ? S_DRAIN : S_REQ;
        end else begin
            case (state_q)
                S_REQ: state_d = S_WAIT;
                S_WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        instr_d       = bus.imem_rsp_data;
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                        pc_d          = pc_q + PC_STEP;
                        state_d       = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (bus.decode_ready) begin
                        instr_valid_d = 1'b0;
                        state_d       = S_WAIT;
                    end
                end
                S_DRAIN: begin
                    if (bus.imem_rsp_valid) begin
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    // FSM and output registers; reset wins over redirect and responses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_stall_q;

    // Handshake and stall counters; they wrap and survive redirects.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (instr_valid_q && bus.decode_ready) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (instr_valid_q && !bus.decode_ready) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule
